// File: rtl/rv32i_fetch_seq_if.sv
// Instruction-memory fetch bus: a request is held with a stable address until the memory acks.
interface rv32i_fetch_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/rv32i_fetch_seq.sv
// Multi-cycle fetch/PC sequencer: fetches one instruction, waits for the core to finish it,
// then picks the next PC and counts the retirement. Misaligned targets and fetch timeouts trap.
module rv32i_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    rv32i_fetch_seq_if.master         bus,
    output logic                      instr_valid,
    output logic [31:0]               instr,
    output logic [31:0]               pc_out,
    input  logic                      exec_done,
    input  logic                      br_taken,
    input  logic                      jal,
    input  logic                      jalr,
    input  logic [31:0]               br_target,
    input  logic [31:0]               jal_target,
    input  logic [31:0]               jalr_target,
    output logic                      misalign_err,
    output logic                      bus_err,
    output logic [31:0]               instret
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_EXEC,
        S_TRAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      instret_q;
    logic [31:0]      next_pc;
    logic             fetch_done;
    logic             timeout_hit;
    logic             retire;
    logic             misalign;

    assign bus.imem_req  = (state == S_REQ);
    assign bus.imem_addr = pc_out;
    assign instret       = instret_q;

    // Same priority as the core's PC mux; jal together with jalr is illegal and falls through.
    always_comb begin
        next_pc = pc_out + 32'd4;
        if (br_taken) begin
            next_pc = br_target;
        end else if (jal && !jalr) begin
            next_pc = jal_target;
        end else if (jalr && !jal) begin
            next_pc = jalr_target;
        end
    end

    always_comb begin
        state_next  = state;
        fetch_done  = 1'b0;
        timeout_hit = 1'b0;
        retire      = 1'b0;
        misalign    = 1'b0;
        case (state)
            S_BOOT: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                // An ack arriving on the last allowed cycle still counts as a normal fetch.
                if (bus.imem_ack) begin
                    fetch_done = 1'b1;
                    state_next = S_EXEC;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = S_TRAP;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (next_pc[1:0] != 2'b00) begin
                        misalign   = 1'b1;
                        state_next = S_TRAP;
                    end else begin
                        retire     = 1'b1;
                        state_next = S_REQ;
                    end
                end
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out       <= RESET_PC;
            instr        <= 32'd0;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            instret_q    <= 32'd0;
            wait_cnt     <= '0;
        end else begin
            instr_valid <= fetch_done;
            wait_cnt    <= (state == S_REQ && !fetch_done && !timeout_hit)
                           ? wait_cnt + 1'b1 : '0;
            if (fetch_done) begin
                instr <= bus.imem_rdata;
            end
            if (retire) begin
                pc_out    <= next_pc;
                instret_q <= instret_q + 32'd1;
            end
            if (misalign) begin
                misalign_err <= 1'b1;
            end
            if (timeout_hit) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule
